// File: rtl/qspi_dispatcher.sv
// QSPI nibble receiver that loads a shared key into a bank of encrypter channels and
// deals assembled packets out to them round-robin with a sequence tag and key rotation.
module qspi_dispatcher #(
  parameter int NUM_CH    = 4,
  parameter int PKT_WIDTH = 32,
  parameter int KEY_WIDTH = 64,
  parameter int TAG_WIDTH = 8,
  parameter int ROT_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [3:0]                         qspi_data,
  input  logic                               qspi_sending,
  output logic                               qspi_ready,
  input  logic                               prog,
  output logic [PKT_WIDTH-1:0]               ch_data,
  output logic [KEY_WIDTH-1:0]               ch_key,
  output logic [ROT_WIDTH-1:0]               ch_key_rotation,
  output logic [TAG_WIDTH-1:0]               ch_tag,
  output logic [$clog2(PKT_WIDTH/4+1)-1:0]   ch_len,
  output logic [NUM_CH-1:0]                  ch_program,
  output logic [NUM_CH-1:0]                  ch_data_ready,
  input  logic [NUM_CH-1:0]                  ch_ready,
  output logic [2:0]                         state_out
);

  localparam int PN    = PKT_WIDTH / 4;
  localparam int KN    = KEY_WIDTH / 4;
  localparam int LEN_W = $clog2(PN + 1);
  localparam int KC_W  = $clog2(KN + 1);
  localparam int PTR_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_LOAD = 3'd1,
    S_KEY_DIST = 3'd2,
    S_STREAM   = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  state_t                 state;
  logic                   key_valid;
  logic [KEY_WIDTH-1:0]   shadow_key;
  logic [KC_W-1:0]        key_cnt;
  logic [PTR_W-1:0]       dist_idx;
  logic [PTR_W-1:0]       ptr;
  logic [TAG_WIDTH-1:0]   tag;
  logic [ROT_WIDTH-1:0]   rot;

  logic [PKT_WIDTH-1:0]   asm_p0;
  logic [LEN_W-1:0]       cnt_p0;
  logic                   pend_p0;
  logic [LEN_W-1:0]       pend_len_p0;
  logic [PKT_WIDTH-1:0]   pkt_p1;
  logic [LEN_W-1:0]       len_p1;
  logic                   vld_p1;

  logic [PKT_WIDTH-1:0]   shifted_pkt;
  logic [KEY_WIDTH-1:0]   shifted_key;
  logic [NUM_CH-1:0]      eligible;
  logic [PTR_W-1:0]       sel;
  logic                   found;
  logic                   dispatch;
  logic                   hold_free;
  logic                   hold_load;
  logic [PKT_WIDTH-1:0]   hold_in;
  logic [LEN_W-1:0]       hold_in_len;

  // Left-justify a short packet so its valid nibbles sit in the MSBs.
  function automatic logic [PKT_WIDTH-1:0] pad_pkt(input logic [PKT_WIDTH-1:0] d,
                                                   input logic [LEN_W-1:0] n);
    return d << (4 * (PN - int'(n)));
  endfunction

  assign state_out   = state;
  assign shifted_pkt = {asm_p0[PKT_WIDTH-5:0], qspi_data};
  assign shifted_key = {shadow_key[KEY_WIDTH-5:0], qspi_data};
  // A channel strobed last cycle is still latching its packet, so skip it once.
  assign eligible    = ch_ready & ~ch_data_ready;
  assign dispatch    = vld_p1 && found;
  assign hold_free   = !vld_p1 || dispatch;

  always_comb begin
    qspi_ready = 1'b0;
    case (state)
      S_IDLE:     qspi_ready = key_valid;
      S_KEY_LOAD: qspi_ready = 1'b1;
      S_STREAM:   qspi_ready = !pend_p0;
      default:    qspi_ready = 1'b0;
    endcase
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && eligible[(int'(ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        sel   = PTR_W'((int'(ptr) + k) % NUM_CH);
      end
    end
  end

  // Assembly (p0) -> holding buffer (p1): a parked packet has priority over a fresh one.
  always_comb begin
    hold_load   = 1'b0;
    hold_in     = asm_p0;
    hold_in_len = pend_len_p0;
    if ((state == S_STREAM || state == S_FLUSH) && hold_free) begin
      if (pend_p0) begin
        hold_load = 1'b1;
      end else if (state == S_STREAM && qspi_sending && cnt_p0 == LEN_W'(PN - 1)) begin
        hold_load   = 1'b1;
        hold_in     = shifted_pkt;
        hold_in_len = LEN_W'(PN);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      key_valid       <= 1'b0;
      shadow_key      <= '0;
      key_cnt         <= '0;
      dist_idx        <= '0;
      ptr             <= '0;
      tag             <= '0;
      rot             <= '0;
      asm_p0          <= '0;
      cnt_p0          <= '0;
      pend_p0         <= 1'b0;
      pend_len_p0     <= '0;
      pkt_p1          <= '0;
      len_p1          <= '0;
      vld_p1          <= 1'b0;
      ch_data         <= '0;
      ch_key          <= '0;
      ch_key_rotation <= '0;
      ch_tag          <= '0;
      ch_len          <= '0;
      ch_program      <= '0;
      ch_data_ready   <= '0;
    end else begin
      ch_program    <= '0;
      ch_data_ready <= '0;
      // Holding buffer (p1) -> channel strobe
      if (dispatch) begin
        ch_data_ready   <= NUM_CH'(1) << sel;
        ch_data         <= pkt_p1;
        ch_len          <= len_p1;
        ch_tag          <= tag;
        ch_key_rotation <= rot;
        tag             <= tag + 1'b1;
        ptr             <= (sel == PTR_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        if (sel == PTR_W'(NUM_CH - 1)) rot <= rot + 1'b1;
      end
      if (hold_load) begin
        pkt_p1 <= hold_in;
        len_p1 <= hold_in_len;
        vld_p1 <= 1'b1;
      end else if (dispatch) begin
        vld_p1 <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (prog) begin
            key_cnt <= '0;
            state   <= S_KEY_LOAD;
          end else if (qspi_sending && key_valid) begin
            asm_p0 <= PKT_WIDTH'(qspi_data);
            cnt_p0 <= LEN_W'(1);
            state  <= S_STREAM;
          end
        end
        S_KEY_LOAD: begin
          if (!qspi_sending) begin
            state <= S_IDLE;
          end else begin
            shadow_key <= shifted_key;
            if (key_cnt == KC_W'(KN - 1)) begin
              ch_key    <= shifted_key;
              key_valid <= 1'b1;
              tag       <= '0;
              rot       <= '0;
              dist_idx  <= '0;
              state     <= S_KEY_DIST;
            end else begin
              key_cnt <= key_cnt + 1'b1;
            end
          end
        end
        S_KEY_DIST: begin
          if (ch_ready[dist_idx]) begin
            ch_program <= NUM_CH'(1) << dist_idx;
            if (dist_idx == PTR_W'(NUM_CH - 1)) state <= S_IDLE;
            else dist_idx <= dist_idx + 1'b1;
          end
        end
        S_STREAM: begin
          if (pend_p0) begin
            if (hold_load) pend_p0 <= 1'b0;
            if (!qspi_sending) state <= S_FLUSH;
          end else if (qspi_sending) begin
            if (cnt_p0 == LEN_W'(PN - 1)) begin
              cnt_p0 <= '0;
              if (!hold_load) begin
                asm_p0      <= shifted_pkt;
                pend_p0     <= 1'b1;
                pend_len_p0 <= LEN_W'(PN);
              end
            end else begin
              asm_p0 <= shifted_pkt;
              cnt_p0 <= cnt_p0 + 1'b1;
            end
          end else begin
            if (cnt_p0 != '0) begin
              asm_p0      <= pad_pkt(asm_p0, cnt_p0);
              pend_p0     <= 1'b1;
              pend_len_p0 <= cnt_p0;
              cnt_p0      <= '0;
            end
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (hold_load) pend_p0 <= 1'b0;
          if (!pend_p0 && !vld_p1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
